sim_mem_model: RTL and testbench

Parametrised simulation memory model; successor to the single-cycle basic memory used in the CPU testbench top.
- Serves one instruction or data port with configurable width, depth and read/write latency.
- Pipelined: accepts one request per cycle.
- Detects the program-exit write (tohost) itself, so the bench no longer probes CPU internals.
- One instance each is used for imem and dmem; contents are preloaded by the bench through the `mem` array.

---
 rtl/sim_mem_model_if.sv | 37 +++
 rtl/sim_mem_model.sv | 134 +++++++++++++
 tb/tb_sim_mem_model.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sim_mem_model_if.sv
// Request/response bundle for sim_mem_model: one instruction or data port.
// The console signals exist only when SIM_MEM_CONSOLE_EN is defined.
interface sim_mem_model_if #(
    parameter int DATA_W = 32,
    parameter int ADR_W  = 32
) ();
    logic                  r_v;
    logic                  w_v;
    logic [ADR_W-1:0]      adr;
    logic [DATA_W-1:0]     data;
    logic [DATA_W/8-1:0]   strobe;
    logic [DATA_W-1:0]     resp;
    logic                  ack;
    logic                  err;
    logic                  exit_v;
    logic [DATA_W-1:0]     exit_code;
`ifdef SIM_MEM_CONSOLE_EN
    logic                  char_v;
    logic [7:0]            char_o;
`endif

    modport master (
        output r_v, w_v, adr, data, strobe,
        input  resp, ack, err, exit_v, exit_code
`ifdef SIM_MEM_CONSOLE_EN
        , input char_v, char_o
`endif
    );

    modport slave (
        input  r_v, w_v, adr, data, strobe,
        output resp, ack, err, exit_v, exit_code
`ifdef SIM_MEM_CONSOLE_EN
        , output char_v, char_o
`endif
    );
endinterface

// File: rtl/sim_mem_model.sv
// Pipelined simulation memory with fixed request-to-ack latency and tohost exit detection.
// Optional console character sink at CONSOLE_ADR enabled by SIM_MEM_CONSOLE_EN.
module sim_mem_model #(
    parameter int               DATA_W      = 32,
    parameter int               DEPTH       = 4096,
    parameter int               ADR_W       = 32,
    parameter int               LATENCY     = 1,
    parameter logic [ADR_W-1:0] EXIT_ADR    = '0,
    parameter logic [ADR_W-1:0] CONSOLE_ADR = ADR_W'(32'h4)
) (
    input  logic              clk,
    input  logic              rst_n,
    sim_mem_model_if.slave    bus
);
    localparam int LANES = DATA_W / 8;
    localparam int OFF   = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW1   = ADR_W + 1;

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("sim_mem_model: LATENCY must be in 1..8");
    end
    if (DATA_W < 8) begin : g_bad_width_min
        $error("sim_mem_model: DATA_W must be at least 8");
    end
    if ((DATA_W & (DATA_W - 1)) != 0) begin : g_bad_width_pow2
        $error("sim_mem_model: DATA_W must be a power of two");
    end
    if (CONSOLE_ADR == EXIT_ADR) begin : g_bad_adr
        $error("sim_mem_model: CONSOLE_ADR and EXIT_ADR must differ");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADR_W-1:0]  word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              in_range;
    logic              req;
    logic              cons_hit;
    logic              wr_en;
    logic [DATA_W-1:0] rd_word;

    assign word_idx = bus.adr >> OFF;
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign in_range = ({1'b0, word_idx} < AW1'(DEPTH));
    assign req      = bus.r_v | bus.w_v;
`ifdef SIM_MEM_CONSOLE_EN
    assign cons_hit = (bus.adr == CONSOLE_ADR);
`else
    assign cons_hit = 1'b0;
`endif
    // Console writes are consumed by the sink and never reach the array.
    assign wr_en    = bus.w_v & in_range & ~cons_hit;
    assign rd_word  = (bus.r_v && in_range) ? mem[mem_idx] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.strobe[i]) mem[mem_idx][i*8 +: 8] <= bus.data[i*8 +: 8];
            end
        end
    end

    // Stage boundary: request enters the LATENCY-deep response pipeline.
    logic [LATENCY-1:0] vld_p;
    logic [LATENCY-1:0] err_p;
    logic [DATA_W-1:0]  dat_p [LATENCY];
    logic [DATA_W-1:0]  resp_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= req;
            for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        err_p[0] <= ~in_range;
        dat_p[0] <= rd_word;
        for (int i = 1; i < LATENCY; i++) begin
            err_p[i] <= err_p[i-1];
            dat_p[i] <= dat_p[i-1];
        end
    end

    // Stage boundary: pipeline output; resp keeps the last acked word between acks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 resp_hold <= '0;
        else if (vld_p[LATENCY-1])  resp_hold <= dat_p[LATENCY-1];
    end

    assign bus.ack  = vld_p[LATENCY-1];
    assign bus.err  = vld_p[LATENCY-1] & err_p[LATENCY-1];
    assign bus.resp = vld_p[LATENCY-1] ? dat_p[LATENCY-1] : resp_hold;

    logic              exit_v_q;
    logic [DATA_W-1:0] exit_code_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exit_v_q    <= 1'b0;
            exit_code_q <= '0;
        end else if (bus.w_v && (bus.adr == EXIT_ADR) && !exit_v_q) begin
            exit_v_q    <= 1'b1;
            exit_code_q <= bus.data;
        end
    end

    assign bus.exit_v    = exit_v_q;
    assign bus.exit_code = exit_code_q;

`ifdef SIM_MEM_CONSOLE_EN
    logic       char_v_q;
    logic [7:0] char_o_q;
    logic       char_hit;

    assign char_hit = bus.w_v & cons_hit & bus.strobe[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_v_q <= 1'b0;
            char_o_q <= '0;
        end else begin
            char_v_q <= char_hit;
            if (char_hit) char_o_q <= bus.data[7:0];
        end
    end

    assign bus.char_v = char_v_q;
    assign bus.char_o = char_o_q;
`endif
endmodule

// File: tb/tb_sim_mem_model.sv
// Directed bench for sim_mem_model: a LATENCY=1 deep instance and a LATENCY=3, DEPTH=16 instance.
module tb_sim_mem_model;
    logic clk;
    logic rst1_n;
    logic rst3_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    sim_mem_model_if #(.DATA_W(32), .ADR_W(32)) bus1 ();
    sim_mem_model_if #(.DATA_W(32), .ADR_W(32)) bus3 ();

    sim_mem_model u1 (.clk(clk), .rst_n(rst1_n), .bus(bus1));
    sim_mem_model #(.DEPTH(16), .LATENCY(3)) u3 (.clk(clk), .rst_n(rst3_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req1(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        bus1.r_v = r; bus1.w_v = w; bus1.adr = a; bus1.data = d; bus1.strobe = s;
        tick();
        bus1.r_v = 1'b0; bus1.w_v = 1'b0;
    endtask

    task automatic req3(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        bus3.r_v = r; bus3.w_v = w; bus3.adr = a; bus3.data = d; bus3.strobe = s;
        tick();
        bus3.r_v = 1'b0; bus3.w_v = 1'b0;
    endtask

    initial begin
        logic saw_ack;
        rst1_n = 1'b0; rst3_n = 1'b0;
        bus1.r_v = 1'b0; bus1.w_v = 1'b0; bus1.adr = '0; bus1.data = '0; bus1.strobe = '0;
        bus3.r_v = 1'b0; bus3.w_v = 1'b0; bus3.adr = '0; bus3.data = '0; bus3.strobe = '0;
        tick(); tick();

        // Reset state
        chk("rst_ack", bus1.ack, 0);
        chk("rst_resp", bus1.resp, 0);
        chk("rst_err", bus1.err, 0);
        chk("rst_exit_v", bus1.exit_v, 0);
        chk("rst_exit_code", bus1.exit_code, 0);
        chk("rst_ack3", bus3.ack, 0);
        rst1_n = 1'b1; rst3_n = 1'b1;
        tick();

        // Test 1: LATENCY=1 write then read
        req1(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
        chk("t1_wr_ack", bus1.ack, 1);
        chk("t1_wr_err", bus1.err, 0);
        chk("t1_wr_resp", bus1.resp, 0);
        req1(1, 0, 32'h10, 32'h0, 4'h0);
        chk("t1_rd_ack", bus1.ack, 1);
        chk("t1_rd_resp", bus1.resp, 32'hDEADBEEF);
        chk("t1_rd_err", bus1.err, 0);
        tick();
        chk("t1_idle_ack", bus1.ack, 0);
        chk("t1_resp_hold", bus1.resp, 32'hDEADBEEF);
        chk("t1_no_exit", bus1.exit_v, 0);

        // Test 2: LATENCY=3 back-to-back reads
        u3.mem[0] = 32'd1; u3.mem[1] = 32'd2; u3.mem[2] = 32'd3; u3.mem[3] = 32'd4;
        bus3.r_v = 1'b1; bus3.adr = 32'h0;
        tick();
        chk("t2_ack_c1", bus3.ack, 0);
        bus3.adr = 32'h4;
        tick();
        chk("t2_ack_c2", bus3.ack, 0);
        bus3.adr = 32'h8;
        tick();
        chk("t2_ack_c3", bus3.ack, 1);
        chk("t2_resp1", bus3.resp, 32'd1);
        bus3.adr = 32'hC;
        tick();
        bus3.r_v = 1'b0;
        chk("t2_ack_c4", bus3.ack, 1);
        chk("t2_resp2", bus3.resp, 32'd2);
        tick();
        chk("t2_ack_c5", bus3.ack, 1);
        chk("t2_resp3", bus3.resp, 32'd3);
        tick();
        chk("t2_ack_c6", bus3.ack, 1);
        chk("t2_resp4", bus3.resp, 32'd4);
        tick();
        chk("t2_ack_c7", bus3.ack, 0);
        chk("t2_resp_hold", bus3.resp, 32'd4);

        // Test 3: byte lanes and read-before-write
        u3.mem[8] = 32'h11223344;
        req3(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101);
        tick(); tick();
        chk("t3_wr_ack", bus3.ack, 1);
        chk("t3_wr_resp", bus3.resp, 0);
        req3(1, 0, 32'h20, 32'h0, 4'h0);
        tick(); tick();
        chk("t3_lane_resp", bus3.resp, 32'h11BB33DD);
        req3(1, 1, 32'h20, 32'hCAFEF00D, 4'hF);
        tick(); tick();
        chk("t3_rbw_ack", bus3.ack, 1);
        chk("t3_rbw_resp", bus3.resp, 32'h11BB33DD);
        req3(1, 0, 32'h20, 32'h0, 4'h0);
        tick(); tick();
        chk("t3_after_rbw", bus3.resp, 32'hCAFEF00D);

        // Test 4: out-of-range on DEPTH=16
        req3(1, 0, 32'h40, 32'h0, 4'h0);
        tick(); tick();
        chk("t4_rd_ack", bus3.ack, 1);
        chk("t4_rd_err", bus3.err, 1);
        chk("t4_rd_resp", bus3.resp, 0);
        req3(0, 1, 32'h44, 32'hFFFFFFFF, 4'hF);
        tick(); tick();
        chk("t4_wr_ack", bus3.ack, 1);
        chk("t4_wr_err", bus3.err, 1);
        req3(1, 0, 32'h4, 32'h0, 4'h0);
        tick(); tick();
        chk("t4_word1_kept", bus3.resp, 32'd2);
        chk("t4_inrange_err", bus3.err, 0);

        // Test 5: exit detection
        req1(0, 1, 32'h0, 32'd7, 4'hF);
        chk("t5_exit_v", bus1.exit_v, 1);
        chk("t5_exit_code", bus1.exit_code, 32'd7);
        req1(0, 1, 32'h0, 32'd9, 4'hF);
        chk("t5_exit_v_sticky", bus1.exit_v, 1);
        chk("t5_exit_code_kept", bus1.exit_code, 32'd7);
        #2; rst1_n = 1'b0; #1;
        chk("t5_rst_exit_v", bus1.exit_v, 0);
        chk("t5_rst_exit_code", bus1.exit_code, 0);
        tick();
        rst1_n = 1'b1;
        req1(1, 0, 32'h0, 32'h0, 4'h0);
        chk("t5_exit_word_stored", bus1.resp, 32'd9);

`ifdef SIM_MEM_CONSOLE_EN
        // Test 6a: console sink
        u1.mem[1] = 32'h12345678;
        req1(0, 1, 32'h4, 32'h00000041, 4'hF);
        chk("t6_char_v", bus1.char_v, 1);
        chk("t6_char_o", bus1.char_o, 32'h41);
        chk("t6_cons_ack", bus1.ack, 1);
        tick();
        chk("t6_char_pulse", bus1.char_v, 0);
        req1(1, 0, 32'h4, 32'h0, 4'h0);
        chk("t6_cons_word", bus1.resp, 32'h12345678);
`endif

        // Test 6b: reset with two requests in flight
        req3(0, 1, 32'h8, 32'h55, 4'hF);
        req3(1, 0, 32'h4, 32'h0, 4'h0);
        #2; rst3_n = 1'b0; #1;
        chk("t6_rst_ack", bus3.ack, 0);
        tick();
        rst3_n = 1'b1;
        saw_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            saw_ack = saw_ack | bus3.ack;
        end
        chk("t6_no_ack_after_rst", saw_ack, 0);
        req3(1, 0, 32'h8, 32'h0, 4'h0);
        tick(); tick();
        chk("t6_committed_write", bus3.resp, 32'h55);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
